da_amplitude_bank: RTL and testbench
====================================

# da_amplitude_bank

Parametrised, clocked register bank that sets the output amplitude codes for NUM_CH DAC channels from the STM32 parallel bus. Writes land in per-channel shadow registers and are applied to all channels together by a commit, or per channel in auto-commit mode. Optional slew-rate-limited ramping moves each output toward its new target. Sits between the bus decode and the DAC drivers; the DA_OUT codes feed the DAC data pins directly.

## Interface
- NUM_CH, 2, number of DAC channels (1..8)
- DW, 12, DAC code width (1..16)
- BASE_ADDR, 16'h000E, address of channel 0 shadow; channel i at BASE_ADDR+i
- CTRL_ADDR, BASE_ADDR+NUM_CH, control register: bit0 COMMIT (self-clearing), bit1 AUTO
- STEP_ADDR, BASE_ADDR+NUM_CH+1, ramp step, DW bits
- DIV_ADDR, BASE_ADDR+NUM_CH+2, ramp tick divider, 16 bits
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- CS  in  1  bus chip select, active-low, asynchronous to CLK
- WR_EN  in  1  bus write enable, active-high, asynchronous
- RD_EN  in  1  bus read enable, active-high, asynchronous
- ADDR  in  16  bus address, stable while CS low
- DATA_in  in  16  bus write data
- DATA_out  out  16  registered readback data
- DA_OUT  out  NUM_CH*DW  channel codes, channel i at [i*DW +: DW]
- BUSY  out  1  high while any output differs from its target

## Operation
- Write qualifier wq = !CS && WR_EN passes through a 2-FF synchroniser. The rising edge of the synchronised signal is a one-cycle write pulse; ADDR/DATA_in are sampled on that cycle. Holding WR_EN high gives exactly one write.
- Channel address write: shadow[i] <= DATA_in[DW-1:0]; upper bits ignored. If AUTO=1, target[i] <= same value in the same cycle.
- CTRL write: AUTO <= DATA_in[1]. If DATA_in[0]=1, every target <= shadow in one cycle. COMMIT is never stored.
- STEP/DIV writes load those registers. Unmapped addresses are ignored.
- Ramp: a divider counter runs 0..DIV and emits a tick when it equals DIV, then wraps to 0. DIV=0 gives a tick every cycle. On a tick, each out[i] moves toward target[i] by min(STEP, |target-out|), so it never overshoots. STEP=0 means an immediate jump on the next cycle.
- Retarget mid-ramp: the ramp continues from the current out value toward the new target. There is no restart glitch.
- Read: when !CS && RD_EN (synchronised the same way, level not edge), DATA_out <= mux(ADDR) each cycle; otherwise DATA_out holds.
  - Channel address returns the current out[i], zero-extended.
  - CTRL returns {14'b0, BUSY, AUTO}.
  - STEP and DIV return their values; unmapped addresses return 0.
- Reset values:
  - shadow, target, out, DA_OUT: 0
  - AUTO: 0; STEP: 1; DIV: 0
  - divider counter: 0; BUSY: 0; DATA_out: 0; synchroniser FFs: 0
- Reset mid-ramp forces all of the above immediately, asynchronously.

## Timing
- Bus write to shadow: write pulse on the 3rd CLK edge after wq rises; shadow/target update on the 4th edge.
- Commit to first output change: 1 cycle after target load when STEP=0. With ramping, at the first tick after target load.
- BUSY is registered and reflects out != target of the previous cycle: one-cycle lag, glitch-free.
- Read latency: DATA_out valid 3 edges after the read qualifier rises. The host holds RD_EN ≥ 4 CLK periods.
- A write pulse in the same cycle as a ramp tick: the tick uses the old target, and the new target is used from the next cycle.

## Configuration
- DA_RAMP_EN defined: divider, STEP/DIV registers and slew logic are present as described.
- DA_RAMP_EN undefined:
  - STEP/DIV registers are removed; their writes are ignored and reads return 0.
  - out[i] <= target[i] every cycle, so DA_OUT follows commit with 1 cycle latency.
  - BUSY is tied to 0.

## Structure
- Package da_amp_pkg: CTRL bit indices (COMMIT=0, AUTO=1), address offsets (NUM_CH, NUM_CH+1, NUM_CH+2), reset constants (STEP_RST=1, DIV_RST=0), synchroniser depth 2.
- Sub-module da_ramp_ch: one per channel, generated NUM_CH times.
  - Inputs: CLK, RST, tick, step, target.
  - Outputs: out, busy.
  - Holds the out register and min/direction arithmetic. The top level owns bus sync, decode, shadows, divider and readback.

## Test plan
- Reset, then write ch0=0x123 with AUTO=0 -> DA_OUT unchanged at 0, shadow readback via CTRL unaffected; write CTRL=0x1 -> DA_OUT[11:0] reaches 0x123, BUSY returns to 0.
- STEP=0x10, DIV=3, commit ch0 0x000→0x045 -> out rises by 0x10 every 4 cycles (0x10,0x20,0x30,0x40), then last step 0x05 lands at 0x045 with no overshoot; BUSY high throughout, low after.
- AUTO=1, write ch1=0xFFF with DATA_in=0xFFFF -> only DA_OUT[23:12] moves and reaches 0xFFF; ch0 unchanged.
- Retarget mid-ramp: ramp ch0 0→0x800 at STEP=1, commit 0x100 when out=0x200 -> out decreases from 0x200 to 0x100 without any jump.
- WR_EN held high for 20 cycles on the CTRL address with COMMIT=1 -> exactly one write pulse; unmapped address 0x0030 write -> no register change; read 0x0030 -> DATA_out=0.
- Assert RST while ch0 is ramping at 0x300 -> DA_OUT=0, BUSY=0, STEP reads 1 after release; without DA_RAMP_EN, commit 0x555 -> DA_OUT=0x555 one cycle after target load and BUSY stays 0.

Source files
------------

// File: rtl/da_amp_pkg.sv
// rtl/da_amp_pkg.sv - shared constants for the DAC amplitude register bank
package da_amp_pkg;

  // CTRL register bit positions (write view)
  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_AUTO_BIT   = 1;

  // Register offsets added to NUM_CH, relative to BASE_ADDR
  localparam int CTRL_OFS = 0;
  localparam int STEP_OFS = 1;
  localparam int DIV_OFS  = 2;

  // Reset values of the ramp configuration registers
  localparam int STEP_RST = 1;
  localparam int DIV_RST  = 0;

  // Depth of the bus qualifier synchronisers
  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/da_ramp_ch.sv
// rtl/da_ramp_ch.sv - one DAC channel output register with optional slew limiting (DA_RAMP_EN)
module da_ramp_ch #(
  parameter int DW = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          tick,
  input  logic [DW-1:0] step,
  input  logic [DW-1:0] target,
  output logic [DW-1:0] out,
  output logic          busy
);

  logic [DW-1:0] out_q, out_d;
  logic          busy_q, busy_d;

`ifdef DA_RAMP_EN
  logic [DW-1:0] diff;
  logic [DW-1:0] delta;

  // Move toward target by min(step, distance); step of zero jumps straight there
  always_comb begin
    diff   = (target >= out_q) ? (target - out_q) : (out_q - target);
    delta  = (step > diff) ? diff : step;
    out_d  = out_q;
    busy_d = (out_q != target);
    if (step == '0) begin
      out_d = target;
    end else if (tick) begin
      out_d = (target >= out_q) ? (out_q + delta) : (out_q - delta);
    end
  end
`else
  logic unused_ramp;
  assign unused_ramp = tick ^ (^step);

  // Without slew limiting the output simply follows the target one cycle later
  always_comb begin
    out_d  = target;
    busy_d = 1'b0;
  end
`endif

  // Output and busy registers, cleared immediately on reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      busy_q <= busy_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;

endmodule

// File: rtl/da_amplitude_bank.sv
// rtl/da_amplitude_bank.sv - DAC amplitude register bank with shadow/commit and optional ramping (DA_RAMP_EN)
module da_amplitude_bank
  import da_amp_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int          DW        = 12,
  parameter logic [15:0] BASE_ADDR = 16'h000E,
  parameter logic [15:0] CTRL_ADDR = BASE_ADDR + 16'(NUM_CH + CTRL_OFS),
  parameter logic [15:0] STEP_ADDR = BASE_ADDR + 16'(NUM_CH + STEP_OFS),
  parameter logic [15:0] DIV_ADDR  = BASE_ADDR + 16'(NUM_CH + DIV_OFS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CS,
  input  logic                 WR_EN,
  input  logic                 RD_EN,
  input  logic [15:0]          ADDR,
  input  logic [15:0]          DATA_in,
  output logic [15:0]          DATA_out,
  output logic [NUM_CH*DW-1:0] DA_OUT,
  output logic                 BUSY
);

  logic                  wq, rq;
  logic [SYNC_DEPTH-1:0] wq_sync_q, wq_sync_d, rq_sync_q, rq_sync_d;
  logic                  wq_last_q, wq_last_d;
  logic                  wr_pulse_q, wr_pulse_d;
  logic [15:0]           data_out_q, data_out_d, rd_data;
  logic                  auto_q, auto_d;
  logic [DW-1:0]         shadow_q [NUM_CH];
  logic [DW-1:0]         shadow_d [NUM_CH];
  logic [DW-1:0]         target_q [NUM_CH];
  logic [DW-1:0]         target_d [NUM_CH];
  logic [DW-1:0]         ch_out   [NUM_CH];
  logic [NUM_CH-1:0]     ch_busy;
  logic                  tick;
  logic [DW-1:0]         step_w;
  logic                  unused_data_in;

  assign wq = ~CS & WR_EN;
  assign rq = ~CS & RD_EN;
  assign unused_data_in = ^DATA_in;

  // Qualifier synchronisers; a write is the registered rising edge of the synced strobe
  always_comb begin
    wq_sync_d  = {wq_sync_q[SYNC_DEPTH-2:0], wq};
    rq_sync_d  = {rq_sync_q[SYNC_DEPTH-2:0], rq};
    wq_last_d  = wq_sync_q[SYNC_DEPTH-1];
    wr_pulse_d = wq_sync_q[SYNC_DEPTH-1] & ~wq_last_q;
  end

`ifdef DA_RAMP_EN
  logic [DW-1:0] step_q, step_d;
  logic [15:0]   div_q, div_d, div_cnt_q, div_cnt_d;

  // Free-running tick divider; >= lets a shrunk DIV take effect without a long wrap
  always_comb begin
    tick      = (div_cnt_q >= div_q);
    div_cnt_d = tick ? 16'd0 : (div_cnt_q + 16'd1);
  end

  // Ramp configuration registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      step_q    <= DW'(STEP_RST);
      div_q     <= 16'(DIV_RST);
      div_cnt_q <= '0;
    end else begin
      step_q    <= step_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign step_w = step_q;
`else
  assign tick   = 1'b0;
  assign step_w = '0;
`endif

  // Register write decode: shadows, AUTO, commit into targets, ramp settings
  always_comb begin
    shadow_d = shadow_q;
    target_d = target_q;
    auto_d   = auto_q;
`ifdef DA_RAMP_EN
    step_d   = step_q;
    div_d    = div_q;
`endif
    if (wr_pulse_q) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ADDR == BASE_ADDR + 16'(i)) begin
          shadow_d[i] = DATA_in[DW-1:0];
          if (auto_q) target_d[i] = DATA_in[DW-1:0];
        end
      end
      if (ADDR == CTRL_ADDR) begin
        auto_d = DATA_in[CTRL_AUTO_BIT];
        if (DATA_in[CTRL_COMMIT_BIT]) target_d = shadow_q;
      end
`ifdef DA_RAMP_EN
      if (ADDR == STEP_ADDR) step_d = DATA_in[DW-1:0];
      if (ADDR == DIV_ADDR)  div_d  = DATA_in;
`endif
    end
  end

  // Readback mux; DATA_out tracks it only while the synced read qualifier is high
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ADDR == BASE_ADDR + 16'(i)) rd_data = 16'(ch_out[i]);
    end
    if (ADDR == CTRL_ADDR) rd_data = {14'b0, BUSY, auto_q};
`ifdef DA_RAMP_EN
    if (ADDR == STEP_ADDR) rd_data = 16'(step_q);
    if (ADDR == DIV_ADDR)  rd_data = div_q;
`else
    if (ADDR == STEP_ADDR || ADDR == DIV_ADDR) rd_data = '0;
`endif
    data_out_d = rq_sync_q[SYNC_DEPTH-1] ? rd_data : data_out_q;
  end

  // Bus-side state registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wq_sync_q  <= '0;
      rq_sync_q  <= '0;
      wq_last_q  <= 1'b0;
      wr_pulse_q <= 1'b0;
      data_out_q <= '0;
      auto_q     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        target_q[i] <= '0;
      end
    end else begin
      wq_sync_q  <= wq_sync_d;
      rq_sync_q  <= rq_sync_d;
      wq_last_q  <= wq_last_d;
      wr_pulse_q <= wr_pulse_d;
      data_out_q <= data_out_d;
      auto_q     <= auto_d;
      shadow_q   <= shadow_d;
      target_q   <= target_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    da_ramp_ch #(.DW(DW)) u_ch (
      .CLK    (CLK),
      .RST    (RST),
      .tick   (tick),
      .step   (step_w),
      .target (target_q[g]),
      .out    (ch_out[g]),
      .busy   (ch_busy[g])
    );
    assign DA_OUT[g*DW +: DW] = ch_out[g];
  end

  assign BUSY     = |ch_busy;
  assign DATA_out = data_out_q;

endmodule

// File: tb/tb_da_amplitude_bank.sv
// tb/tb_da_amplitude_bank.sv - self-checking bench for da_amplitude_bank (ramp checks under DA_RAMP_EN)
module tb_da_amplitude_bank;

`ifdef DA_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, CS, WR_EN, RD_EN;
  logic [15:0] ADDR, DATA_in;
  logic [15:0] DATA_out;
  logic [23:0] DA_OUT;
  logic        BUSY;

  int n_tests = 0;
  int n_fail  = 0;

  da_amplitude_bank #(.NUM_CH(2), .DW(12), .BASE_ADDR(16'h000E)) dut (
    .CLK(CLK), .RST(RST), .CS(CS), .WR_EN(WR_EN), .RD_EN(RD_EN),
    .ADDR(ADDR), .DATA_in(DATA_in), .DATA_out(DATA_out),
    .DA_OUT(DA_OUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_rd;
    logic [23:0] exp_da;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit wr, input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] er, input logic [23:0] eda);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp_rd = er; v.exp_da = eda;
    vt.push_back(v);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge CLK);
    CS = 1'b0; ADDR = a; DATA_in = d; WR_EN = 1'b1;
    repeat (6) @(negedge CLK);
    WR_EN = 1'b0; CS = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge CLK);
    CS = 1'b0; ADDR = a; RD_EN = 1'b1;
    repeat (5) @(negedge CLK);
    d = DATA_out;
    RD_EN = 1'b0; CS = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    logic [15:0] rd;
    logic [11:0] cur, prev, peak;
    int          w, k, last_c, jumps;
    logic [11:0] rs [5];

    // ch0=0x0E ch1=0x0F CTRL=0x10 STEP=0x11 DIV=0x12
    add(1, 16'h0011, 16'h0000, 16'h0000, 24'h000000);
    add(1, 16'h000E, 16'h0123, 16'h0000, 24'h000000);
    add(0, 16'h0010, 16'h0000, 16'h0000, 24'h000000);
    add(0, 16'h000E, 16'h0000, 16'h0000, 24'h000000);
    add(1, 16'h0010, 16'h0001, 16'h0000, 24'h000123);
    add(0, 16'h000E, 16'h0000, 16'h0123, 24'h000123);
    add(0, 16'h0011, 16'h0000, 16'h0000, 24'h000123);
    add(1, 16'h0012, 16'h0005, 16'h0000, 24'h000123);
    add(0, 16'h0012, 16'h0000, RAMP ? 16'h0005 : 16'h0000, 24'h000123);
    add(1, 16'h0010, 16'h0002, 16'h0000, 24'h000123);
    add(0, 16'h0010, 16'h0000, 16'h0001, 24'h000123);
    add(1, 16'h000F, 16'hFFFF, 16'h0000, 24'hFFF123);
    add(0, 16'h000F, 16'h0000, 16'h0FFF, 24'hFFF123);
    add(1, 16'h0030, 16'hABCD, 16'h0000, 24'hFFF123);
    add(0, 16'h0030, 16'h0000, 16'h0000, 24'hFFF123);
    add(1, 16'h000E, 16'h0000, 16'h0000, 24'hFFF000);
    add(1, 16'h0010, 16'h0000, 16'h0000, 24'hFFF000);
    add(1, 16'h000E, 16'h0555, 16'h0000, 24'hFFF000);
    add(0, 16'h000E, 16'h0000, 16'h0000, 24'hFFF000);
    add(1, 16'h0010, 16'h0001, 16'h0000, 24'hFFF555);
    add(1, 16'h0012, 16'h0000, 16'h0000, 24'hFFF555);

    RST = 1'b1; CS = 1'b1; WR_EN = 1'b0; RD_EN = 1'b0; ADDR = '0; DATA_in = '0;
    repeat (3) @(negedge CLK);
    check("reset_da_out", DA_OUT, 0);
    check("reset_busy", BUSY, 0);
    check("reset_data_out", DATA_out, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].wr) begin
        bus_write(vt[i].addr, vt[i].data);
      end else begin
        bus_read(vt[i].addr, rd);
        check($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
      end
      check($sformatf("vec%0d_da", i), DA_OUT, vt[i].exp_da);
      check($sformatf("vec%0d_busy", i), BUSY, 0);
    end

    // commit latency: target loads on 4th edge, output on 5th
    bus_write(16'h000E, 16'h02AA);
    @(negedge CLK);
    CS = 1'b0; ADDR = 16'h0010; DATA_in = 16'h0001; WR_EN = 1'b1;
    repeat (4) @(negedge CLK);
    check("commit_lat_before", DA_OUT[11:0], 12'h555);
    @(negedge CLK);
    check("commit_lat_after", DA_OUT[11:0], 12'h2AA);
    repeat (2) @(negedge CLK);
    WR_EN = 1'b0; CS = 1'b1;
    repeat (3) @(negedge CLK);

    // read latency: DATA_out valid 3 edges after the qualifier rises
    CS = 1'b0; ADDR = 16'h000E; RD_EN = 1'b1;
    repeat (2) @(negedge CLK);
    check("read_lat_before", DATA_out, 16'h0000);
    @(negedge CLK);
    check("read_lat_after", DATA_out, 16'h02AA);
    RD_EN = 1'b0; CS = 1'b1;
    repeat (3) @(negedge CLK);

    // WR_EN held 20 cycles: only the first sampled data may land
    bus_write(16'h0010, 16'h0002);
    @(negedge CLK);
    CS = 1'b0; ADDR = 16'h000E; DATA_in = 16'h00AA; WR_EN = 1'b1;
    repeat (6) @(negedge CLK);
    DATA_in = 16'h00BB;
    repeat (14) @(negedge CLK);
    check("held_wr_ch0", DA_OUT, 24'hFFF0AA);
    WR_EN = 1'b0; CS = 1'b1;
    repeat (3) @(negedge CLK);
    @(negedge CLK);
    CS = 1'b0; ADDR = 16'h0010; DATA_in = 16'h0003; WR_EN = 1'b1;
    repeat (6) @(negedge CLK);
    DATA_in = 16'h0000;
    repeat (14) @(negedge CLK);
    WR_EN = 1'b0; CS = 1'b1;
    repeat (3) @(negedge CLK);
    bus_read(16'h0010, rd);
    check("held_wr_ctrl", rd, 16'h0001);
    check("held_wr_da", DA_OUT, 24'hFFF0AA);

`ifdef DA_RAMP_EN
    // STEP=0x10 DIV=3 ramp 0 -> 0x45
    rs[0] = 12'h010; rs[1] = 12'h020; rs[2] = 12'h030; rs[3] = 12'h040; rs[4] = 12'h045;
    bus_write(16'h0010, 16'h0000);
    bus_write(16'h000E, 16'h0000);
    bus_write(16'h0010, 16'h0001);
    bus_write(16'h0011, 16'h0010);
    bus_write(16'h0012, 16'h0003);
    bus_write(16'h000E, 16'h0045);
    check("ramp_start_zero", DA_OUT[11:0], 12'h000);
    @(negedge CLK);
    CS = 1'b0; ADDR = 16'h0010; DATA_in = 16'h0001; WR_EN = 1'b1;
    prev = DA_OUT[11:0]; k = 0; last_c = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (c == 6) begin WR_EN = 1'b0; CS = 1'b1; end
      cur = DA_OUT[11:0];
      if (cur != prev) begin
        if (k < 5) check($sformatf("ramp_val%0d", k), cur, rs[k]);
        if (k > 0 && k < 5) check($sformatf("ramp_gap%0d", k), c - last_c, 4);
        if (cur != 12'h045) check($sformatf("ramp_busy%0d", k), BUSY, 1);
        k++; last_c = c;
      end
      prev = cur;
    end
    check("ramp_final", DA_OUT[11:0], 12'h045);
    check("ramp_steps", k, 5);
    check("ramp_busy_done", BUSY, 0);

    // retarget mid-ramp: 0 -> 0x800, recommit 0x100 near 0x200
    bus_write(16'h0011, 16'h0001);
    bus_write(16'h0012, 16'h0000);
    bus_write(16'h000E, 16'h0800);
    bus_write(16'h0010, 16'h0001);
    bus_write(16'h000E, 16'h0100);
    w = 0;
    while (DA_OUT[11:0] < 12'h200 && w < 3000) begin @(negedge CLK); w++; end
    check("retarget_reach", (w < 3000), 1);
    @(negedge CLK);
    CS = 1'b0; ADDR = 16'h0010; DATA_in = 16'h0001; WR_EN = 1'b1;
    prev = DA_OUT[11:0]; peak = prev; jumps = 0;
    for (int c = 0; c < 900; c++) begin
      @(negedge CLK);
      if (c == 6) begin WR_EN = 1'b0; CS = 1'b1; end
      cur = DA_OUT[11:0];
      if (((cur > prev) ? (cur - prev) : (prev - cur)) > 12'd1) jumps++;
      if (cur > peak) peak = cur;
      prev = cur;
    end
    check("retarget_no_jump", jumps, 0);
    check("retarget_peak_ok", (peak >= 12'h200 && peak < 12'h220), 1);
    check("retarget_final", DA_OUT[11:0], 12'h100);
    check("retarget_busy", BUSY, 0);

    // ramp toward 0x800 so reset lands mid-ramp
    bus_write(16'h000E, 16'h0800);
    bus_write(16'h0010, 16'h0001);
    w = 0;
    while (DA_OUT[11:0] < 12'h300 && w < 3000) begin @(negedge CLK); w++; end
    check("rst_ramp_reach", (w < 3000), 1);
    check("rst_ramp_busy", BUSY, 1);
`endif

    // asynchronous reset takes effect without a clock edge
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("rst_async_da", DA_OUT, 0);
    check("rst_async_busy", BUSY, 0);
    check("rst_async_data_out", DATA_out, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    bus_read(16'h0011, rd);
    check("rst_step_read", rd, RAMP ? 16'h0001 : 16'h0000);
    bus_read(16'h0010, rd);
    check("rst_ctrl_read", rd, 16'h0000);
    check("rst_da_after", DA_OUT, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
